// File: rtl/wait_timer_multi.sv
// Multi-channel wait timer: each channel counts shared ticks up to a latched limit, then pulses done.
// Optional shared tick prescaler compiled in with `define WAIT_TIMER_PRESCALE_EN.
module wait_timer_multi #(
    parameter int WIDTH          = 16,
    parameter int CHANNELS       = 2,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    input  logic [CHANNELS-1:0]       periodic,
    input  logic [CHANNELS*WIDTH-1:0] limit,
    input  logic [CHANNELS-1:0]       clear_exp,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       expired,
    output logic [CHANNELS*WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    logic tick;

`ifdef WAIT_TIMER_PRESCALE_EN
    logic [PRESCALE_WIDTH-1:0] div_reg;
    logic [PRESCALE_WIDTH-1:0] div_next;
    logic                      div_wrap;

    // >= rather than == so a prescale lowered mid-count cannot strand the divider
    always_comb begin
        div_wrap = (div_reg >= prescale);
        tick     = enable && div_wrap;
        div_next = div_reg;
        if (enable) begin
            div_next = div_wrap ? '0 : div_reg + PRESCALE_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_next;
        end
    end
`else
    logic unused_prescale;
    assign unused_prescale = ^prescale;
    assign tick            = enable;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            state_t             state_reg, state_next;
            logic [WIDTH-1:0]   count_reg, count_next;
            logic [WIDTH-1:0]   limit_reg, limit_next;
            logic               periodic_reg, periodic_next;
            logic               done_reg, done_next;
            logic               expired_reg, expired_next;
            logic               hit;

            always_comb begin
                state_next    = state_reg;
                count_next    = count_reg;
                limit_next    = limit_reg;
                periodic_next = periodic_reg;
                done_next     = 1'b0;
                hit           = 1'b0;

                // Priority: stop, then start, then counting; start suppresses an expiring tick.
                if (stop[gi]) begin
                    state_next = ST_IDLE;
                end else if (start[gi]) begin
                    state_next    = ST_RUN;
                    count_next    = '0;
                    limit_next    = limit[gi*WIDTH +: WIDTH];
                    periodic_next = periodic[gi];
                end else if (state_reg == ST_RUN && tick) begin
                    if (count_reg != limit_reg) begin
                        count_next = count_reg + WIDTH'(1);
                    end else begin
                        hit       = 1'b1;
                        done_next = 1'b1;
                        if (periodic_reg) begin
                            count_next = '0;
                        end else begin
                            state_next = ST_EXPIRED;
                        end
                    end
                end

                if (hit) begin
                    expired_next = 1'b1;
                end else if (clear_exp[gi]) begin
                    expired_next = 1'b0;
                end else begin
                    expired_next = expired_reg;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    state_reg    <= ST_IDLE;
                    count_reg    <= '0;
                    limit_reg    <= '0;
                    periodic_reg <= 1'b0;
                    done_reg     <= 1'b0;
                    expired_reg  <= 1'b0;
                end else begin
                    state_reg    <= state_next;
                    count_reg    <= count_next;
                    limit_reg    <= limit_next;
                    periodic_reg <= periodic_next;
                    done_reg     <= done_next;
                    expired_reg  <= expired_next;
                end
            end

            assign busy[gi]                   = (state_reg == ST_RUN);
            assign done[gi]                   = done_reg;
            assign expired[gi]                = expired_reg;
            assign count[gi*WIDTH +: WIDTH]   = count_reg;
        end
    endgenerate

endmodule

// File: tb/tb_wait_timer_multi.sv
// Scoreboard bench for wait_timer_multi: expected done cycles are queued at start, matched by a done monitor.
module tb_wait_timer_multi;
    localparam int W  = 16;
    localparam int CH = 2;
    localparam int PW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic [PW-1:0] prescale;
    logic [CH-1:0] start, stop, periodic, clear_exp;
    logic [CH*W-1:0] limit;
    logic [CH-1:0] busy, done, expired;
    logic [CH*W-1:0] count;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    int exp_q0[$];
    int exp_q1[$];
    int s, s2;

    wait_timer_multi #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_WIDTH(PW)) dut (
        .clock(clock), .reset(reset), .enable(enable), .prescale(prescale),
        .start(start), .stop(stop), .periodic(periodic), .limit(limit),
        .clear_exp(clear_exp), .busy(busy), .done(done), .expired(expired),
        .count(count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [1:0] mask, input logic [15:0] l0, input logic [15:0] l1,
                            input logic [1:0] per, input logic [1:0] stp, output int s_out);
        start    = mask;
        stop     = stp;
        limit    = {l1, l0};
        periodic = per;
        step();
        s_out = cyc;
        start = '0;
        stop  = '0;
        $display("cycle %0d: start mask=%b stop=%b limit0=%0d limit1=%0d periodic=%b", cyc, mask, stp, l0, l1, per);
    endtask

    // Done monitor: every pulse must match the oldest queued expectation for its channel.
    always @(posedge clock) begin
        #2;
        if (done[0] === 1'b1) begin
            $display("cycle %0d: done ch0", cyc);
            if (exp_q0.size() == 0) check("done0_unexpected", cyc, -1);
            else check("done0_cycle", cyc, exp_q0.pop_front());
        end
        if (done[1] === 1'b1) begin
            $display("cycle %0d: done ch1", cyc);
            if (exp_q1.size() == 0) check("done1_unexpected", cyc, -1);
            else check("done1_cycle", cyc, exp_q1.pop_front());
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b0; prescale = '0; start = '0; stop = '0;
        periodic = '0; clear_exp = '0; limit = '0;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_expired", expired, 0);
        check("rst_count", count, 0);
        reset = 1'b0;
        enable = 1'b1;

        // one-shot limit 3 on ch0
        do_start(2'b01, 16'd3, 16'd0, 2'b00, 2'b00, s);
        exp_q0.push_back(s + 4);
        check("t1_count0", count[15:0], 0);
        check("t1_busy", busy[0], 1);
        repeat (3) step();
        check("t1_count3", count[15:0], 3);
        check("t1_busy_run", busy[0], 1);
        step();
        check("t1_busy_exp", busy[0], 0);
        check("t1_expired", expired[0], 1);
        check("t1_count_hold", count[15:0], 3);
        step();
        check("t1_count_hold2", count[15:0], 3);
        check("t1_pending", exp_q0.size(), 0);

        // periodic limit 1 on ch1, then stop on what would be an expiry tick
        do_start(2'b10, 16'd0, 16'd1, 2'b10, 2'b00, s);
        for (int k = 1; k <= 5; k++) exp_q1.push_back(s + 2 * k);
        repeat (11) step();
        check("t2_count", count[31:16], 1);
        check("t2_busy", busy[1], 1);
        stop = 2'b10;
        step();
        stop = '0;
        check("t2_stop_busy", busy[1], 0);
        check("t2_stop_count", count[31:16], 1);
        step();
        check("t2_frozen", count[31:16], 1);
        check("t2_expired", expired[1], 1);
        check("t2_pending", exp_q1.size(), 0);

        // clear, then limit 0 expires on the first tick
        clear_exp = 2'b01;
        step();
        clear_exp = '0;
        check("t3_cleared", expired[0], 0);
        do_start(2'b01, 16'd0, 16'd0, 2'b00, 2'b00, s);
        exp_q0.push_back(s + 1);
        step();
        check("t3_l0_busy", busy[0], 0);
        check("t3_l0_exp", expired[0], 1);
        check("t3_l0_count", count[15:0], 0);
        step();
        check("t3_l0_pending", exp_q0.size(), 0);

        // full-range limit: no wrap
        do_start(2'b01, 16'hFFFF, 16'd0, 2'b00, 2'b00, s);
        exp_q0.push_back(s + 65536);
        repeat (65535) step();
        check("t3_max_count", count[15:0], 16'hFFFF);
        check("t3_max_busy", busy[0], 1);
        step();
        check("t3_max_done_busy", busy[0], 0);
        check("t3_max_hold", count[15:0], 16'hFFFF);
        step();
        check("t3_max_pending", exp_q0.size(), 0);

        // 50% enable doubles expiry time
        do_start(2'b10, 16'd0, 16'd4, 2'b00, 2'b00, s);
        exp_q1.push_back(s + 10);
        for (int i = 1; i <= 10; i++) begin
            enable = (i % 2 == 0);
            step();
        end
        enable = 1'b1;
        check("t3_half_busy", busy[1], 0);
        check("t3_half_count", count[31:16], 4);
        step();
        check("t3_half_pending", exp_q1.size(), 0);

        // start and stop together: stop wins
        do_start(2'b10, 16'd0, 16'd7, 2'b00, 2'b10, s);
        check("t4_ss_busy", busy[1], 0);
        check("t4_ss_count", count[31:16], 4);

        // clear_exp in the expiry cycle: set wins
        clear_exp = 2'b01;
        do_start(2'b01, 16'd1, 16'd0, 2'b00, 2'b00, s);
        clear_exp = '0;
        exp_q0.push_back(s + 2);
        check("t4_pre_clear", expired[0], 0);
        step();
        clear_exp = 2'b01;
        step();
        clear_exp = '0;
        check("t4_set_wins", expired[0], 1);
        step();
        check("t4_clr_pending", exp_q0.size(), 0);

        // restart on the expiring tick: no done, count restarts
        do_start(2'b01, 16'd2, 16'd0, 2'b00, 2'b00, s);
        repeat (2) step();
        check("t4_rs_count2", count[15:0], 2);
        do_start(2'b01, 16'd2, 16'd0, 2'b00, 2'b00, s2);
        exp_q0.push_back(s2 + 3);
        check("t4_rs_count0", count[15:0], 0);
        check("t4_rs_busy", busy[0], 1);
        repeat (3) step();
        check("t4_rs_end_busy", busy[0], 0);
        step();
        check("t4_rs_pending", exp_q0.size(), 0);

        // reset mid-run
        do_start(2'b01, 16'd10, 16'd0, 2'b00, 2'b00, s);
        repeat (5) step();
        check("t5_count5", count[15:0], 5);
        reset = 1'b1;
        step();
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_expired", expired, 0);
        check("t5_rst_count", count, 0);
        reset = 1'b0;

        // both channels concurrently
        do_start(2'b11, 16'd3, 16'd2, 2'b10, 2'b00, s);
        exp_q0.push_back(s + 4);
        exp_q1.push_back(s + 3);
        exp_q1.push_back(s + 6);
        exp_q1.push_back(s + 9);
        repeat (9) step();
        check("t5_c0_count", count[15:0], 3);
        check("t5_c0_busy", busy[0], 0);
        check("t5_c1_count", count[31:16], 0);
        check("t5_c1_busy", busy[1], 1);
        stop = 2'b10;
        step();
        stop = '0;
        step();
        check("t5_pending0", exp_q0.size(), 0);
        check("t5_pending1", exp_q1.size(), 0);

        // prescaler
        prescale = 8'd3;
        do_start(2'b01, 16'd2, 16'd0, 2'b00, 2'b00, s);
`ifdef WAIT_TIMER_PRESCALE_EN
        exp_q0.push_back(s + 11);
`else
        exp_q0.push_back(s + 3);
`endif
        repeat (12) step();
        check("t6_busy", busy[0], 0);
        check("t6_count", count[15:0], 2);
        check("t6_expired", expired[0], 1);
        prescale = '0;
        step();
        check("t6_pending", exp_q0.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
